// File: rtl/epochtv1_scandbl.sv
// epochtv1_scandbl: line-doubling scan converter for the Epoch TV-1 video stream.
// Each active input line is written into one bank of a ping-pong line buffer.
// The previous line is then read back twice at CE2 rate, so two output lines
// are produced per input line.
// Optional build macro: EPOCHTV1_SCANDBL_SCANLINE_EN dims the second repetition
// of every line to 50% per channel (scanline effect).
module epochtv1_scandbl #(
  parameter int MAXW = 256,
  parameter int HSW2 = 16
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  logic        CE2,
  input  logic        DE_I,
  input  logic        HS_I,
  input  logic        VS_I,
  input  logic [23:0] RGB_I,
  output logic        DE_O,
  output logic        HS_O,
  output logic        VS_O,
  output logic [23:0] RGB_O
);

  localparam int AW = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] MAXW_C = LW'(MAXW);
  localparam logic [9:0]    HSW2_C = 10'(HSW2);

  // Input-side state (advances on CE only)
  logic          hs_d;
  logic [9:0]    icnt;
  logic [9:0]    icnt_now;
  logic [9:0]    p_q;
  logic [9:0]    s_q;
  logic [9:0]    s_cur;
  logic          de_seen;
  logic [LW-1:0] wptr;
  logic [LW-1:0] len_q;
  logic          wbank;
  logic          vs_l;
  logic          seen_one;
  logic          valid;

  // Output-side state (advances on CE2 only)
  logic [9:0]    ocnt;
  logic          rep;

  // Next-state view, so the output tick coincident with an HS rise already
  // sees the geometry of the line that just completed.
  logic [9:0]    p_n;
  logic [9:0]    s_n;
  logic [LW-1:0] len_n;
  logic          wbank_n;
  logic          vs_n;
  logic          valid_n;
  logic [9:0]    ocnt_n;
  logic          rep_n;
  logic [AW-1:0] rd_off;
  logic [10:0]   s_ext;
  logic [10:0]   o_ext;
  logic [10:0]   e_ext;
  logic          in_line;

  // Pipeline: s1 = computed on the CE2 edge, s2 = buffer read, then outputs.
  logic          de_s1;
  logic          hs_s1;
  logic          vs_s1;
  logic          rbank_s1;
  logic [AW-1:0] raddr_s1;
  logic          de_s2;
  logic          hs_s2;
  logic          vs_s2;
  logic [23:0]   rdata;
  logic [23:0]   pix;
`ifdef EPOCHTV1_SCANDBL_SCANLINE_EN
  logic          rep_s1;
  logic          rep_s2;
`endif

  // Ping-pong line buffer; bank is the address MSB.
  logic [23:0]   mem [0:(2 << AW) - 1];
  logic          we;
  logic [AW:0]   waddr;

  logic hs_rise;
  assign hs_rise = CE & HS_I & ~hs_d;

  assign we    = CE & DE_I & ~hs_rise & (wptr < MAXW_C);
  assign waddr = {wbank, wptr[AW-1:0]};

  // Next-state values for line geometry and the output pixel counter
  always_comb begin
    icnt_now = (icnt == 10'h3FF) ? icnt : icnt + 10'd1;
    p_n      = p_q;
    s_n      = s_q;
    len_n    = len_q;
    wbank_n  = wbank;
    vs_n     = vs_l;
    valid_n  = valid;
    if (hs_rise) begin
      p_n     = icnt_now;
      s_n     = s_cur;
      len_n   = wptr;
      wbank_n = ~wbank;
      vs_n    = VS_I;
      valid_n = valid | seen_one;
    end
    ocnt_n = ocnt + 10'd1;
    rep_n  = rep;
    if (hs_rise) begin
      ocnt_n = 10'd0;
      rep_n  = 1'b0;
    end else if ((p_q != 10'd0) && (ocnt == p_q - 10'd1)) begin
      ocnt_n = 10'd0;
      rep_n  = 1'b1;
    end
    rd_off  = ocnt_n[AW-1:0] - s_n[AW-1:0];
    s_ext   = {1'b0, s_n};
    o_ext   = {1'b0, ocnt_n};
    e_ext   = s_ext + 11'(len_n);
    in_line = (o_ext >= s_ext) && (o_ext < e_ext);
  end

  // Input side: line period, active start, write pointer and bank toggle
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      hs_d     <= 1'b0;
      icnt     <= '0;
      p_q      <= '0;
      s_q      <= '0;
      s_cur    <= '0;
      de_seen  <= 1'b0;
      wptr     <= '0;
      len_q    <= '0;
      wbank    <= 1'b0;
      vs_l     <= 1'b0;
      seen_one <= 1'b0;
      valid    <= 1'b0;
    end else if (CE) begin
      hs_d  <= HS_I;
      p_q   <= p_n;
      s_q   <= s_n;
      len_q <= len_n;
      wbank <= wbank_n;
      vs_l  <= vs_n;
      valid <= valid_n;
      if (hs_rise) begin
        icnt     <= '0;
        wptr     <= '0;
        s_cur    <= '0;
        de_seen  <= 1'b0;
        seen_one <= 1'b1;
      end else begin
        icnt <= icnt_now;
        if (DE_I) begin
          if (!de_seen) begin
            s_cur   <= icnt_now;
            de_seen <= 1'b1;
          end
          if (wptr < MAXW_C) wptr <= wptr + LW'(1);
        end
      end
    end
  end

  // Output side: pixel counter, repetition flag and per-tick output decode
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      ocnt     <= '0;
      rep      <= 1'b0;
      de_s1    <= 1'b0;
      hs_s1    <= 1'b0;
      vs_s1    <= 1'b0;
      rbank_s1 <= 1'b0;
      raddr_s1 <= '0;
`ifdef EPOCHTV1_SCANDBL_SCANLINE_EN
      rep_s1   <= 1'b0;
`endif
    end else if (CE2) begin
      ocnt     <= ocnt_n;
      rep      <= rep_n;
      de_s1    <= valid_n & in_line;
      hs_s1    <= valid_n & (ocnt_n < HSW2_C);
      vs_s1    <= valid_n & vs_n;
      rbank_s1 <= ~wbank_n;
      raddr_s1 <= rd_off;
`ifdef EPOCHTV1_SCANDBL_SCANLINE_EN
      rep_s1   <= rep_n;
`endif
    end
  end

  // Line buffer write port and synchronous read port
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= RGB_I;
    rdata <= mem[{rbank_s1, raddr_s1}];
  end

  // Align control with the buffer read latency
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      de_s2  <= 1'b0;
      hs_s2  <= 1'b0;
      vs_s2  <= 1'b0;
`ifdef EPOCHTV1_SCANDBL_SCANLINE_EN
      rep_s2 <= 1'b0;
`endif
    end else begin
      de_s2  <= de_s1;
      hs_s2  <= hs_s1;
      vs_s2  <= vs_s1;
`ifdef EPOCHTV1_SCANDBL_SCANLINE_EN
      rep_s2 <= rep_s1;
`endif
    end
  end

`ifdef EPOCHTV1_SCANDBL_SCANLINE_EN
  assign pix = rep_s2 ? {1'b0, rdata[23:17], 1'b0, rdata[15:9], 1'b0, rdata[7:1]} : rdata;
`else
  assign pix = rdata;
`endif

  // Registered outputs; pixel forced to black outside the active window
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      DE_O  <= 1'b0;
      HS_O  <= 1'b0;
      VS_O  <= 1'b0;
      RGB_O <= '0;
    end else begin
      DE_O  <= de_s2;
      HS_O  <= hs_s2;
      VS_O  <= vs_s2;
      RGB_O <= de_s2 ? pix : 24'h0;
    end
  end

endmodule

// File: tb/tb_epochtv1_scandbl.sv
// Directed bench for epochtv1_scandbl: CE every second CLK, CE2 every CLK.
// Expected pixels are queued per output line; window statistics are
// collected relative to each input HS rise.
module tb_epochtv1_scandbl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        ce2 = 1'b1;
  logic        de_i = 1'b0;
  logic        hs_i = 1'b0;
  logic        vs_i = 1'b0;
  logic [23:0] rgb_i = 24'h0;
  logic        de_o;
  logic        hs_o;
  logic        vs_o;
  logic [23:0] rgb_o;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int rise_cyc = 0;

  logic [23:0] exp_q[$];
  logic [23:0] line_px [0:299];

  int   de_hi, de_runs, de_off1, de_off2, hs_hi, hs_runs, vs_hi, rgb_idle_nz;
  logic vs_r0, vs_r1;
  logic de_prev = 1'b0;
  logic hs_prev = 1'b0;

  epochtv1_scandbl #(.MAXW(256), .HSW2(16)) dut (
    .CLK  (clk),
    .RES  (rst),
    .CE   (ce),
    .CE2  (ce2),
    .DE_I (de_i),
    .HS_I (hs_i),
    .VS_I (vs_i),
    .RGB_I(rgb_i),
    .DE_O (de_o),
    .HS_O (hs_o),
    .VS_O (vs_o),
    .RGB_O(rgb_o)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] dim(input logic [23:0] c);
`ifdef EPOCHTV1_SCANDBL_SCANLINE_EN
    return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
`else
    return c;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    de_hi = 0; de_runs = 0; de_off1 = -1; de_off2 = -1;
    hs_hi = 0; hs_runs = 0; vs_hi = 0; rgb_idle_nz = 0;
    vs_r0 = 1'b0; vs_r1 = 1'b0;
  endtask

  // Monitor / scoreboard: sample outputs mid-cycle
  always @(negedge clk) begin : mon
    int off;
    off = cyc - rise_cyc;
    if (de_o) begin
      de_hi++;
      if (!de_prev) begin
        de_runs++;
        if (de_runs == 1) de_off1 = off;
        if (de_runs == 2) de_off2 = off;
      end
      if (exp_q.size() > 0) check("pix", {8'h0, rgb_o}, {8'h0, exp_q.pop_front()});
    end else if (rgb_o != 24'h0) begin
      rgb_idle_nz++;
    end
    if (hs_o) begin
      hs_hi++;
      if (!hs_prev) hs_runs++;
    end
    if (vs_o) vs_hi++;
    if (off == 10)  vs_r0 = vs_o;
    if (off == 240) vs_r1 = vs_o;
    de_prev = de_o;
    hs_prev = hs_o;
  end

  // One CE period: act 1 marks the HS rise, act 2 injects a reset pulse
  task automatic ce_tick(input logic de, input logic hs, input logic vs,
                         input logic [23:0] rgb, input int act);
    de_i = de; hs_i = hs; vs_i = vs; rgb_i = rgb; ce = 1'b1;
    @(posedge clk); #1;
    if (act == 1) begin
      rise_cyc = cyc;
      clear_stats();
    end else if (act == 2) begin
      check("pre_rst_de", {31'h0, de_o}, 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_de",  {31'h0, de_o}, 32'd0);
      check("mid_rst_hs",  {31'h0, hs_o}, 32'd0);
      check("mid_rst_vs",  {31'h0, vs_o}, 32'd0);
      check("mid_rst_rgb", {8'h0, rgb_o}, 32'd0);
      rst = 1'b0;
      exp_q.delete();
      rise_cyc = cyc;
      clear_stats();
    end
    ce = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_line(input int period, input int start, input int npix,
                           input logic vs, input int rst_tick);
    for (int k = 0; k < period; k++) begin
      logic de;
      logic hs;
      int   act;
      hs  = (k < 8);
      de  = (k >= start) && (k < start + npix);
      act = (k == 0) ? 1 : ((k == rst_tick) ? 2 : 0);
      ce_tick(de, hs, vs, de ? line_px[k - start] : 24'h0, act);
    end
    @(negedge clk); #1;
  endtask

  task automatic push_exp(input int n, input int nrep);
    for (int r = 0; r < nrep; r++)
      for (int i = 0; i < n; i++)
        exp_q.push_back((r == 0) ? line_px[i] : dim(line_px[i]));
  endtask

  initial begin
    clear_stats();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_de",  {31'h0, de_o}, 32'd0);
    check("rst_hs",  {31'h0, hs_o}, 32'd0);
    check("rst_vs",  {31'h0, vs_o}, 32'd0);
    check("rst_rgb", {8'h0, rgb_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Line A: first HS rise, output must stay blank (VS_I high too)
    line_px[0] = 24'h112233; line_px[1] = 24'h445566;
    line_px[2] = 24'h778899; line_px[3] = 24'hAABBCC;
    send_line(228, 40, 4, 1'b1, -1);
    check("pv_de_hi", de_hi, 0);
    check("pv_hs_hi", hs_hi, 0);
    check("pv_vs_hi", vs_hi, 0);
    check("pv_rgb_idle", rgb_idle_nz, 0);

    // Line B: second HS rise with VS_I=1, line A replayed twice
    push_exp(4, 2);
    line_px[0] = 24'hDEADBE; line_px[1] = 24'h123456;
    line_px[2] = 24'hFEDCBA; line_px[3] = 24'h00FF00;
    send_line(228, 40, 4, 1'b1, -1);
    check("a_de_hi", de_hi, 8);
    check("a_de_runs", de_runs, 2);
    check("a_de_off1", de_off1, 42);
    check("a_de_off2", de_off2, 270);
    check("a_hs_hi", hs_hi, 32);
    check("a_hs_runs", hs_runs, 2);
    check("a_vs_r0", {31'h0, vs_r0}, 32'd1);
    check("a_vs_r1", {31'h0, vs_r1}, 32'd1);
    check("a_q_left", exp_q.size(), 0);
    check("a_rgb_idle", rgb_idle_nz, 0);

    // Line C: 300-pixel line, 400-tick period; B (P=228) wraps four times here
    push_exp(4, 4);
    for (int i = 0; i < 300; i++) line_px[i] = 24'h5A0000 | 24'(i);
    send_line(400, 10, 300, 1'b0, -1);
    check("b_de_hi", de_hi, 16);
    check("b_de_runs", de_runs, 4);
    check("b_de_off1", de_off1, 42);
    check("b_de_off2", de_off2, 270);
    check("b_hs_runs", hs_runs, 4);
    check("b_vs_r0", {31'h0, vs_r0}, 32'd0);
    check("b_vs_r1", {31'h0, vs_r1}, 32'd0);
    check("b_q_left", exp_q.size(), 0);

    // Line D: replays C truncated to 256 pixels
    push_exp(256, 2);
    line_px[0] = 24'h010203; line_px[1] = 24'h040506;
    line_px[2] = 24'h070809; line_px[3] = 24'h0A0B0C;
    send_line(400, 40, 4, 1'b0, -1);
    check("c_de_hi", de_hi, 512);
    check("c_de_runs", de_runs, 2);
    check("c_de_off1", de_off1, 12);
    check("c_de_off2", de_off2, 412);
    check("c_hs_hi", hs_hi, 32);
    check("c_q_left", exp_q.size(), 0);
    check("c_rgb_idle", rgb_idle_nz, 0);

    // Line E: reset pulse while D's first pixel is on the output
    push_exp(4, 2);
    send_line(228, 40, 4, 1'b0, 21);
    check("e_de_hi", de_hi, 0);

    // Line F: first HS rise after reset, still blank
    line_px[0] = 24'hFF8001; line_px[1] = 24'h00FF7E;
    line_px[2] = 24'h808080; line_px[3] = 24'h01FE03;
    send_line(228, 40, 4, 1'b0, -1);
    check("f_de_hi", de_hi, 0);
    check("f_hs_hi", hs_hi, 0);
    check("f_vs_hi", vs_hi, 0);

    // Line G: second rise after reset, F replayed (rep 1 dimmed when enabled)
    push_exp(4, 2);
    line_px[0] = 24'h13579B; line_px[1] = 24'h2468AC;
    line_px[2] = 24'hCAFE00; line_px[3] = 24'h0000FF;
    send_line(228, 40, 4, 1'b0, -1);
    check("g_de_hi", de_hi, 8);
    check("g_de_off1", de_off1, 42);
    check("g_de_off2", de_off2, 270);
    check("g_q_left", exp_q.size(), 0);
    check("g_rgb_idle", rgb_idle_nz, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/epochtv1_scandbl.md
# epochtv1_scandbl

Line-doubling scan converter downstream of the Epoch TV-1 video output. It consumes the CE-qualified `DE`/`HS`/`VS`/`RGB` pixel stream and stores each active line in one half of a ping-pong line buffer. It replays the previous line twice at double pixel rate, giving 31 kHz-class output for VGA-style sinks and the scaler.

## Interface
Parameters:
- `MAXW`, 256: line buffer depth in pixels per bank.
- `HSW2`, 16: output HS pulse width in CE2 ticks.

Ports:
- `CLK` in 1: system clock, 2×14.318181 MHz.
- `RES` in 1: asynchronous, active-high reset.
- `CE` in 1: input pixel-clock enable, same strobe as fed to epochtv1.
- `CE2` in 1: output enable. Exactly two pulses per CE period, one coincident with `CE`.
- `DE_I` in 1: input data enable, from epochtv1 `DE`.
- `HS_I` in 1: input horizontal sync, from epochtv1 `HS`.
- `VS_I` in 1: input vertical sync, from epochtv1 `VS`.
- `RGB_I` in 24: input pixel {R,G,B}, from epochtv1 `RGB`.
- `DE_O` out 1: output data enable.
- `HS_O` out 1: output horizontal sync, active high.
- `VS_O` out 1: output vertical sync.
- `RGB_O` out 24: output pixel; 0 whenever `DE_O`=0.

## Operation
- All input signals are sampled only on `CLK` edges with `CE`=1. All output state advances only on `CE2`.
- Input side. `icnt` is a 10-bit saturating counter of CE ticks since the last `HS_I` rising edge. On each `HS_I` rise:
  - `P` ← `icnt`, the line period in CE ticks.
  - `icnt` ← 0.
  - `wbank` toggles.
  - `vs_l` ← `VS_I`.
- On the first `DE_I`=1 tick after an HS rise, latch `S` ← `icnt` (active start offset).
- While `DE_I`=1, write `RGB_I` to `buf[wbank][wptr]`, then `wptr`++. Writes with `wptr` ≥ `MAXW` are dropped and `wptr` saturates.
- On the HS rise, latch `LEN` ← `wptr` and clear `wptr`. `LEN`, `S` and `P` are sampled together, so all three describe the line just completed.
- `valid` sets after the second HS rise since reset. Until then `DE_O`=`HS_O`=`VS_O`=0.
- Output side. `ocnt` is a 10-bit counter incremented per CE2 tick.
  - Forced to 0 on the CE2 tick coincident with the CE that sampled the HS rise.
  - Also wraps to 0 when `ocnt`==`P`−1. This starts the second repetition (`rep`=1); the HS rise clears `rep`.
- Output derivation per CE2 tick:
  - `HS_O` = `valid` & (`ocnt` < `HSW2`).
  - `DE_O` = `valid` & (`S` ≤ `ocnt` < `S`+`LEN`).
  - Read address = `ocnt`−`S` into bank `~wbank`, i.e. the previous line.
  - `VS_O` = `vs_l`, held constant across both repetitions.
- Simultaneous write and read never collide: the two banks are always opposite.
- `P`=0 (HS stuck) means no wrap. The output keeps repeating the first repetition until the next HS rise.

## Timing
- Buffer read is synchronous. `DE_O`, `HS_O`, `VS_O` and `RGB_O` are all registered and appear exactly 2 `CLK` after the CE2 edge that computed them. They are mutually aligned and held until the next update.
- Line latency: input line N is output during input line N+1, in both halves.
- Reset values: all outputs 0, `wbank`=0, `valid`=0. All counters and latches are 0. Buffer contents are undefined.
- `RES` mid-line: everything returns to reset immediately. No output until two further HS rises.
- `LEN` > `P`−`S` (malformed timing): `DE_O` is truncated at the wrap, never carried into the next repetition.

## Configuration
- `EPOCHTV1_SCANDBL_SCANLINE_EN`
  - Defined: during `rep`=1 each channel is output as `{1'b0, c[7:1]}`, i.e. 50% scanline dimming.
  - Undefined: both repetitions are identical, and `rep` only drives the wrap logic.

## Test plan
- Reset, then 2 HS rises with P=228, S=40, 4-pixel line `0x112233,0x445566,0x778899,0xAABBCC` → after the 2nd HS rise:
  - `DE_O` high for exactly 4 CE2 ticks starting at `ocnt`=40, carrying those values.
  - The same 4 values repeat after `ocnt` wraps at 227.
  - `HS_O` pulses twice per input line, 16 CE2 ticks each.
- Before the 2nd HS rise after reset, with active input → `DE_O`=`HS_O`=`VS_O`=0 and `RGB_O`=0.
- 300-pixel active line with MAXW=256 → `LEN`=256. The output shows pixels 0–255 only, with no wrap into bank contents.
- `VS_I`=1 at an HS rise → `VS_O`=1 through both repetitions of the following output line; cleared on the next line with `VS_I`=0.
- Assert `RES` mid-output → all outputs 0 within 2 CLK. No `DE_O` until 2 more HS rises.
- With `EPOCHTV1_SCANDBL_SCANLINE_EN`, pixel `0xFF8001` → repetition 0 outputs `0xFF8001`, repetition 1 outputs `0x7F4000`.
